act_loader: RTL and testbench

ACT_LOADER -- requirements
Module: act_loader

---
 rtl/act_loader_pkg.sv | 18 +
 rtl/act_loader_if.sv | 30 +++
 rtl/act_loader_fifo.sv | 69 ++++++
 rtl/act_loader.sv | 96 +++++++++
 tb/tb_act_loader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/act_loader_pkg.sv
// Shared configuration for the activation loader: data widths, FIFO geometry
// and the loader FSM state encoding.
package act_loader_pkg;

    localparam int HW_D1            = 4;
    localparam int ADDRM_MAX        = 2;
    localparam int ACT_DATA_LEN     = 16;
    localparam int ACTBUF_WORDS_LEN = 8;
    localparam int ACT_FIFO_DEPTH   = 4;
    localparam int ACT_FIFO_PTR_LEN = $clog2(ACT_FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_STREAM = 2'd1,
        LD_DONE   = 2'd2
    } ld_state_e;

endpackage

// File: rtl/act_loader_if.sv
// Upstream activation stream plus the ACTBUF write port of the loader.
interface act_loader_if;
    import act_loader_pkg::*;

    logic [ACT_DATA_LEN-1:0] act_in_data;
    logic                    act_in_vld;
    logic                    act_in_rdy;
    logic                    actbuf_wr_req;
    logic                    actbuf_wr_vld;
    logic [ACT_DATA_LEN-1:0] actbuf_wr_data;

    modport master (
        output act_in_data,
        output act_in_vld,
        output actbuf_wr_req,
        input  act_in_rdy,
        input  actbuf_wr_vld,
        input  actbuf_wr_data
    );

    modport slave (
        input  act_in_data,
        input  act_in_vld,
        input  actbuf_wr_req,
        output act_in_rdy,
        output actbuf_wr_vld,
        output actbuf_wr_data
    );

endinterface

// File: rtl/act_loader_fifo.sv
// First-word-fall-through FIFO between the upstream stream and ACTBUF writes.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module act_fifo
    import act_loader_pkg::*;
#(
    parameter int DEPTH = ACT_FIFO_DEPTH,
    parameter int WIDTH = ACT_DATA_LEN
) (
    input  logic             clk_l,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             alive_q, alive_d;
    logic             full;
    logic             push;
    logic             do_pop;

    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    // Ready is held low while in reset and released one edge after rst_n rises.
    assign in_rdy   = alive_q & ~full;
    assign push     = in_vld & in_rdy;
    assign do_pop   = pop & ~empty;
    assign out_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        alive_d  = 1'b1;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            alive_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            alive_q  <= alive_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/act_loader.sv
// Streams exactly cfg_reg buffered activation words into ACTBUF per update
// request; words beyond the current update wait in the FIFO.
module act_loader
    import act_loader_pkg::*;
(
    input  logic                        clk_l,
    input  logic                        rst_n,
    input  logic [ACTBUF_WORDS_LEN-1:0] cfg_words,
    input  logic                        cfg_en,
    act_loader_if.slave                 bus,
    output logic                        ld_busy,
    output logic                        ld_done_pulse
);

    ld_state_e                   state_q, state_d;
    logic [ACTBUF_WORDS_LEN-1:0] count_q, count_d;
    logic [ACTBUF_WORDS_LEN-1:0] cfg_q, cfg_d;
    logic                        fifo_empty;
    logic [ACT_DATA_LEN-1:0]     fifo_head;
    logic                        wr_vld;
    logic                        done;
    logic                        last_word;

    act_fifo #(
        .DEPTH (ACT_FIFO_DEPTH),
        .WIDTH (ACT_DATA_LEN)
    ) u_fifo (
        .clk_l    (clk_l),
        .rst_n    (rst_n),
        .in_data  (bus.act_in_data),
        .in_vld   (bus.act_in_vld),
        .in_rdy   (bus.act_in_rdy),
        .pop      (wr_vld),
        .out_data (fifo_head),
        .empty    (fifo_empty)
    );

    assign last_word = (count_q == cfg_q - ACTBUF_WORDS_LEN'(1));

    // Starting an update freezes cfg_reg; new values are only taken while idle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cfg_d   = cfg_q;
        wr_vld  = 1'b0;
        done    = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (bus.actbuf_wr_req && (cfg_q != '0)) begin
                    state_d = LD_STREAM;
                    count_d = '0;
                end else if (cfg_en) begin
                    cfg_d = cfg_words;
                end
            end
            LD_STREAM: begin
                wr_vld = ~fifo_empty;
                if (wr_vld) begin
                    if (last_word) begin
                        done    = 1'b1;
                        count_d = '0;
                        state_d = LD_DONE;
                    end else begin
                        count_d = count_q + ACTBUF_WORDS_LEN'(1);
                    end
                end
            end
            LD_DONE: begin
                if (!bus.actbuf_wr_req) begin
                    state_d = LD_IDLE;
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
            count_q <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cfg_q   <= cfg_d;
        end
    end

    assign bus.actbuf_wr_vld  = wr_vld;
    assign bus.actbuf_wr_data = wr_vld ? fifo_head : '0;
    assign ld_busy            = (state_q != LD_IDLE);
    assign ld_done_pulse      = done;

endmodule

// File: tb/tb_act_loader.sv
// Bench for act_loader: directed scenarios plus random traffic, every cycle
// compared against a word-queue model of the loader's update rules.
module tb_act_loader;
    import act_loader_pkg::*;

    logic                        clk_l = 1'b0;
    logic                        rst_n;
    logic [ACTBUF_WORDS_LEN-1:0] cfg_words;
    logic                        cfg_en;
    logic                        ld_busy;
    logic                        ld_done_pulse;

    act_loader_if bus ();

    act_loader dut (
        .clk_l         (clk_l),
        .rst_n         (rst_n),
        .cfg_words     (cfg_words),
        .cfg_en        (cfg_en),
        .bus           (bus),
        .ld_busy       (ld_busy),
        .ld_done_pulse (ld_done_pulse)
    );

    always #5 clk_l = ~clk_l;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: queued words, update phase (0 idle, 1 streaming, 2 finished),
    // configured length, words delivered in the current update.
    logic [ACT_DATA_LEN-1:0] mq[$];
    int m_phase;
    int m_cfg;
    int m_cnt;
    bit m_alive;

    int obs_vld;
    int obs_done;
    int obs_rdy_low;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic clearObs();
        obs_vld     = 0;
        obs_done    = 0;
        obs_rdy_low = 0;
    endtask

    task automatic applyStimulus(input bit vld, input logic [ACT_DATA_LEN-1:0] data, input bit req,
                                 input bit en, input logic [ACTBUF_WORDS_LEN-1:0] words,
                                 output bit accepted);
        bit exp_rdy, exp_vld, exp_done, exp_busy;
        bus.act_in_vld    = vld;
        bus.act_in_data   = data;
        bus.actbuf_wr_req = req;
        cfg_en            = en;
        cfg_words         = words;
        @(negedge clk_l);
        exp_rdy  = m_alive && (mq.size() < ACT_FIFO_DEPTH);
        exp_vld  = (m_phase == 1) && (mq.size() > 0);
        exp_done = exp_vld && (m_cnt + 1 == m_cfg);
        exp_busy = (m_phase != 0);
        checkOutput("act_in_rdy", 32'(bus.act_in_rdy), 32'(exp_rdy));
        checkOutput("actbuf_wr_vld", 32'(bus.actbuf_wr_vld), 32'(exp_vld));
        if (exp_vld) checkOutput("actbuf_wr_data", 32'(bus.actbuf_wr_data), 32'(mq[0]));
        checkOutput("ld_done_pulse", 32'(ld_done_pulse), 32'(exp_done));
        checkOutput("ld_busy", 32'(ld_busy), 32'(exp_busy));
        if (bus.actbuf_wr_vld === 1'b1) obs_vld++;
        if (ld_done_pulse === 1'b1) obs_done++;
        if (bus.act_in_rdy !== 1'b1) obs_rdy_low++;
        accepted = vld && exp_rdy;
        if (exp_vld) void'(mq.pop_front());
        if (accepted) mq.push_back(data);
        case (m_phase)
            0: begin
                if (req && m_cfg != 0) begin
                    m_phase = 1;
                    m_cnt   = 0;
                end else if (en) begin
                    m_cfg = int'(words);
                end
            end
            1: begin
                if (exp_vld) begin
                    m_cnt++;
                    if (m_cnt == m_cfg) begin
                        m_phase = 2;
                        m_cnt   = 0;
                    end
                end
            end
            default: if (!req) m_phase = 0;
        endcase
        m_alive = 1'b1;
        @(posedge clk_l);
        #1;
    endtask

    task automatic doReset();
        bus.act_in_vld    = 1'b0;
        bus.act_in_data   = '0;
        bus.actbuf_wr_req = 1'b0;
        cfg_en            = 1'b0;
        cfg_words         = '0;
        rst_n             = 1'b0;
        #2;
        checkOutput("rst_rdy", 32'(bus.act_in_rdy), 32'd0);
        checkOutput("rst_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        checkOutput("rst_data", 32'(bus.actbuf_wr_data), 32'd0);
        checkOutput("rst_busy", 32'(ld_busy), 32'd0);
        checkOutput("rst_done", 32'(ld_done_pulse), 32'd0);
        mq.delete();
        m_phase = 0;
        m_cfg   = 0;
        m_cnt   = 0;
        m_alive = 1'b0;
        @(posedge clk_l);
        @(posedge clk_l);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic loadCfg(input logic [ACTBUF_WORDS_LEN-1:0] w);
        bit acc;
        applyStimulus(1'b0, '0, 1'b0, 1'b1, w, acc);
    endtask

    task automatic idleCycle(input bit req);
        bit acc;
        applyStimulus(1'b0, '0, req, 1'b0, '0, acc);
    endtask

    initial begin
        #40_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int idx;
        rst_n = 1'b0;
        #1;
        doReset();

        // Eight words streamed back to back with the request held.
        loadCfg(8'd8);
        clearObs();
        idx = 1;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(idx <= 8, 16'(idx), 1'b1, 1'b0, '0, acc);
            if (acc) idx++;
        end
        checkOutput("s1_vld_cnt", 32'(obs_vld), 32'd8);
        checkOutput("s1_done_cnt", 32'(obs_done), 32'd1);
        checkOutput("s1_in_done", 32'(ld_busy), 32'd1);
        idleCycle(1'b0);

        // Ten words offered against a four-word update; the rest must wait.
        doReset();
        loadCfg(8'd4);
        clearObs();
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            applyStimulus(idx < 10, 16'(16'h100 + idx), 1'b1, 1'b0, '0, acc);
            if (acc) idx++;
        end
        checkOutput("s2_first_vld_cnt", 32'(obs_vld), 32'd4);
        checkOutput("s2_rdy_full", 32'(bus.act_in_rdy), 32'd0);
        applyStimulus(idx < 10, 16'(16'h100 + idx), 1'b0, 1'b0, '0, acc);
        if (acc) idx++;
        clearObs();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(idx < 10, 16'(16'h100 + idx), 1'b1, 1'b0, '0, acc);
            if (acc) idx++;
        end
        checkOutput("s2_second_vld_cnt", 32'(obs_vld), 32'd4);
        checkOutput("s2_second_done_cnt", 32'(obs_done), 32'd1);

        // Gappy upstream with a six-word update.
        doReset();
        loadCfg(8'd6);
        clearObs();
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus((c % 2 == 0) && idx < 6, 16'(16'h300 + idx), 1'b1, 1'b0, '0, acc);
            if (acc) idx++;
        end
        checkOutput("s3_vld_cnt", 32'(obs_vld), 32'd6);
        checkOutput("s3_done_cnt", 32'(obs_done), 32'd1);
        idleCycle(1'b0);

        // Steady push and pop at three entries across pointer wrap.
        doReset();
        loadCfg(8'd26);
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 16'(16'h400 + idx), 1'b0, 1'b0, '0, acc);
            if (acc) idx++;
        end
        idleCycle(1'b1);
        clearObs();
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, 16'(16'h400 + idx), 1'b1, 1'b0, '0, acc);
            if (acc) idx++;
        end
        checkOutput("s4_rdy_low_cnt", 32'(obs_rdy_low), 32'd0);
        checkOutput("s4_vld_cnt", 32'(obs_vld), 32'd20);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(idx < 26, 16'(16'h400 + idx), 1'b1, 1'b0, '0, acc);
            if (acc) idx++;
        end
        checkOutput("s4_done_cnt", 32'(obs_done), 32'd1);
        idleCycle(1'b0);

        // Zero-length configuration never starts; mid-update reconfig is ignored.
        doReset();
        loadCfg(8'd0);
        clearObs();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 16'(16'h500 + c), 1'b1, 1'b0, '0, acc);
        end
        checkOutput("s5_zero_vld_cnt", 32'(obs_vld), 32'd0);
        checkOutput("s5_zero_busy", 32'(ld_busy), 32'd0);
        idleCycle(1'b0);
        loadCfg(8'd3);
        clearObs();
        idleCycle(1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 8'd5, acc);
        for (int c = 0; c < 6; c++) idleCycle(1'b1);
        checkOutput("s5_old_cfg_vld_cnt", 32'(obs_vld), 32'd3);
        checkOutput("s5_old_cfg_done_cnt", 32'(obs_done), 32'd1);

        // Reset after three words of an eight-word update, then a fresh update.
        doReset();
        loadCfg(8'd8);
        idx = 1;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 16'(16'h600 + idx), 1'b1, 1'b0, '0, acc);
            if (acc) idx++;
        end
        doReset();
        loadCfg(8'd8);
        clearObs();
        idx = 1;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(idx <= 8, 16'(16'h700 + idx), 1'b1, 1'b0, '0, acc);
            if (acc) idx++;
        end
        checkOutput("s6_vld_cnt", 32'(obs_vld), 32'd8);
        checkOutput("s6_done_cnt", 32'(obs_done), 32'd1);

        // Random traffic, requests and reconfiguration.
        doReset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom % 4) != 0, 16'($urandom), ($urandom % 8) != 0,
                          ($urandom % 16) == 0, 8'($urandom_range(1, 6)), acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
